imem_fetch_sequencer: RTL and testbench



---
 rtl/imem_fetch_sequencer.sv | 133 +++++++++++++
 tb/tb_imem_fetch_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_sequencer.sv
// Instruction-fetch sequencer: drives the async-read imem with the PC
// and hands fetched words to decode through a one-entry output register.
module imem_fetch_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 32,
  parameter int RESET_PC  = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  // One extra bit so the bound compares cleanly for any ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_instr_q;
  logic [ADDR_W-1:0]   out_pc_q;
  logic                halted_q;
  logic                fault_q;
  logic [CNT_W-1:0]    cnt_q;

  logic advance;
  logic transfer;
  logic rd_ok;
  logic pc_ok;

  assign advance  = !out_valid_q || out_ready;
  assign transfer = out_valid_q && out_ready;
  assign rd_ok    = {1'b0, redirect_pc} < DEPTH_X;
  assign pc_ok    = {1'b0, pc_q} < DEPTH_X;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RST_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          out_valid_q <= 1'b0;
          if (redirect_valid) begin
            if (rd_ok) pc_q <= redirect_pc;
          end else if (start) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (redirect_valid) begin
            // Presented word is dropped; decode restarts at the target.
            out_valid_q <= 1'b0;
            if (rd_ok) begin
              pc_q <= redirect_pc;
            end else begin
              fault_q  <= 1'b1;
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
          end else if (stop) begin
            if (transfer) out_valid_q <= 1'b0;
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else if (!pc_ok && advance) begin
            if (transfer) out_valid_q <= 1'b0;
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else if (advance) begin
            out_instr_q <= imem_rdata;
            out_pc_q    <= pc_q;
            out_valid_q <= 1'b1;
            pc_q        <= pc_q + 1'b1;
            cnt_q       <= cnt_q + 1'b1;
          end
        end
        S_HALT: begin
          if (transfer) out_valid_q <= 1'b0;
          if (redirect_valid) begin
            if (rd_ok) begin
              pc_q        <= redirect_pc;
              halted_q    <= 1'b0;
              fault_q     <= 1'b0;
              out_valid_q <= 1'b0;
              state_q     <= S_RUN;
            end else begin
              fault_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: directed stimulus with a queue
// scoreboard popped by a monitor on every decode handshake.
module tb_imem_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic        fault;
  logic [15:0] fetch_count;

  imem_fetch_sequencer #(
    .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(32),
    .RESET_PC(0), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .halted(halted),
    .fault(fault),
    .fetch_count(fetch_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [32];
  int          n_tests;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr < 32) ? mem[imem_addr[4:0]]
                                       : 32'hFFFF_FFFF;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      exp_t e;
      e.pc    = 32'(i);
      e.instr = mem[i];
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every handshake must match the next expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got pc %0d expected none", out_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word_pc", 64'(out_pc), 64'(e.pc));
        chk("word_instr", 64'(out_instr), 64'(e.instr));
      end
    end
  end

  initial begin
    mem[0] = 32'h2D90_0093;
    mem[1] = 32'h3E80_0113;
    for (int i = 2; i < 32; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_count", 64'(fetch_count), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_valid", 64'(out_valid), 64'd0);
      chk("idle_addr", 64'(imem_addr), 64'd0);
    end

    // Start and stream words 0..3, then backpressure on word 3.
    push_range(0, 3);
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("count_2", 64'(fetch_count), 64'd2);
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_pc", 64'(out_pc), 64'd3);
      chk("bp_instr", 64'(out_instr), 64'(mem[3]));
      chk("bp_addr", 64'(imem_addr), 64'd4);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("after_bp_pc", 64'(out_pc), 64'd4);

    // Redirect drops the held word; then redirect+stop stays in RUN.
    redirect_valid = 1'b1; redirect_pc = 32'd20;
    tick();
    redirect_valid = 1'b0;
    chk("redir_valid", 64'(out_valid), 64'd0);
    chk("redir_addr", 64'(imem_addr), 64'd20);
    tick();
    chk("w20_pc", 64'(out_pc), 64'd20);
    chk("w20_valid", 64'(out_valid), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 32'd22; stop = 1'b1;
    tick();
    redirect_valid = 1'b0; stop = 1'b0;
    chk("rs_valid", 64'(out_valid), 64'd0);
    chk("rs_halted", 64'(halted), 64'd0);
    chk("rs_addr", 64'(imem_addr), 64'd22);

    // Run to end of memory.
    push_range(22, 31);
    out_ready = 1'b1;
    for (int k = 0; k < 40 && !halted; k++) tick();
    chk("eom_halted", 64'(halted), 64'd1);
    chk("eom_fault", 64'(fault), 64'd0);
    chk("eom_valid", 64'(out_valid), 64'd0);
    chk("eom_addr", 64'(imem_addr), 64'd32);
    chk("eom_count", 64'(fetch_count), 64'd16);
    chk("eom_drained", 64'(exp_q.size()), 64'd0);

    start = 1'b1; stop = 1'b1;
    tick();
    tick();
    start = 1'b0; stop = 1'b0;
    chk("halt_hold", 64'(halted), 64'd1);
    chk("halt_count", 64'(fetch_count), 64'd16);

    // Resume at 0, then out-of-range redirect faults.
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    tick();
    redirect_valid = 1'b0;
    chk("resume_halted", 64'(halted), 64'd0);
    chk("resume_addr", 64'(imem_addr), 64'd0);
    tick();
    chk("resume_pc", 64'(out_pc), 64'd0);
    chk("resume_count", 64'(fetch_count), 64'd17);
    redirect_valid = 1'b1; redirect_pc = 32'd40;
    tick();
    chk("flt_halted", 64'(halted), 64'd1);
    chk("flt_fault", 64'(fault), 64'd1);
    chk("flt_valid", 64'(out_valid), 64'd0);
    chk("flt_addr", 64'(imem_addr), 64'd1);
    push_range(5, 5);
    redirect_pc = 32'd5; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("flt_clr", 64'(fault), 64'd0);
    chk("flt_run", 64'(halted), 64'd0);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_halted", 64'(halted), 64'd1);
    chk("stop_valid", 64'(out_valid), 64'd0);
    chk("stop_count", 64'(fetch_count), 64'd18);
    chk("stop_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with a word pending.
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'd10;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(fetch_count), 64'd0);
    chk("arst_addr", 64'(imem_addr), 64'd0);
    chk("arst_halted", 64'(halted), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
